test_monitor: RTL and testbench

TEST_MONITOR -- requirements
Module: test_monitor

---
 rtl/test_monitor.sv | 113 +++++++++++
 tb/tb_test_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/test_monitor.sv
// Watches an alloc_test run: tracks RUN cycles, detects completion or timeout,
// captures the debug word and drives a status RGB LED.
module test_monitor #(
    parameter logic [31:0] TIMEOUT    = 32'd10000,
    parameter int          BLINK_BITS = 22
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_running,
    input  logic        i_passed,
    input  logic [63:0] i_debug,
    output logic [1:0]  o_state,
    output logic        o_done,
    output logic        o_timeout,
    output logic [31:0] o_cycles,
    output logic [63:0] o_snapshot,
    output logic        o_red,
    output logic        o_grn,
    output logic        o_blu
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           cycles_q, cycles_d;
    logic                  seen_q, seen_d;
    logic                  timeout_q, timeout_d;
    logic [63:0]           snapshot_q, snapshot_d;
    logic [BLINK_BITS-1:0] blink_q, blink_d;
    logic                  red_q, red_d;
    logic                  grn_q, grn_d;
    logic                  blu_q, blu_d;

    always_comb begin
        state_d    = state_q;
        cycles_d   = cycles_q;
        seen_d     = seen_q;
        timeout_d  = timeout_q;
        snapshot_d = snapshot_q;
        blink_d    = blink_q + BLINK_BITS'(1);
        unique case (state_q)
            IDLE: begin
                if (i_en) begin
                    state_d  = RUN;
                    cycles_d = 32'd0;
                end
            end
            RUN: begin
                cycles_d = cycles_q + 32'd1;
                if (i_running) begin
                    seen_d = 1'b1;
                end
                // completion wins over a timeout landing on the same edge
                if (seen_q && !i_running) begin
                    state_d    = i_passed ? PASS : FAIL;
                    snapshot_d = i_debug;
                end else if (cycles_q == TIMEOUT - 32'd1) begin
                    state_d    = FAIL;
                    timeout_d  = 1'b1;
                    snapshot_d = i_debug;
                end
            end
            default: ;
        endcase
    end

    // LEDs are decoded from the current state so they lag it by one cycle
    always_comb begin
        red_d = (state_q == FAIL) && blink_q[BLINK_BITS-1];
        grn_d = (state_q == PASS);
        blu_d = (state_q == RUN);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cycles_q   <= '0;
            seen_q     <= 1'b0;
            timeout_q  <= 1'b0;
            snapshot_q <= '0;
            blink_q    <= '0;
            red_q      <= 1'b0;
            grn_q      <= 1'b0;
            blu_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycles_q   <= cycles_d;
            seen_q     <= seen_d;
            timeout_q  <= timeout_d;
            snapshot_q <= snapshot_d;
            blink_q    <= blink_d;
            red_q      <= red_d;
            grn_q      <= grn_d;
            blu_q      <= blu_d;
        end
    end

    assign o_state    = state_q;
    assign o_done     = (state_q == PASS) || (state_q == FAIL);
    assign o_timeout  = timeout_q;
    assign o_cycles   = cycles_q;
    assign o_snapshot = snapshot_q;
    assign o_red      = red_q;
    assign o_grn      = grn_q;
    assign o_blu      = blu_q;

endmodule

// File: tb/tb_test_monitor.sv
// Randomized run scenarios for test_monitor checked against a
// behavioural model of the monitor's rules.
module tb_test_monitor;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        running;
    logic        passed;
    logic [63:0] debug;
    logic [1:0]  st;
    logic        done;
    logic        tmo;
    logic [31:0] cycles;
    logic [63:0] snap;
    logic        red;
    logic        grn;
    logic        blu;

    test_monitor #(
        .TIMEOUT   (32'd100),
        .BLINK_BITS(4)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_running (running),
        .i_passed  (passed),
        .i_debug   (debug),
        .o_state   (st),
        .o_done    (done),
        .o_timeout (tmo),
        .o_cycles  (cycles),
        .o_snapshot(snap),
        .o_red     (red),
        .o_grn     (grn),
        .o_blu     (blu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model: 0 idle, 1 run, 2 pass, 3 fail
    int          m_st;
    int          m_cyc;
    int          m_blink;
    bit          m_seen;
    bit          m_tmo;
    logic [63:0] m_snap;
    bit          m_red;
    bit          m_grn;
    bit          m_blu;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st    = 0;
        m_cyc   = 0;
        m_blink = 0;
        m_seen  = 0;
        m_tmo   = 0;
        m_snap  = '0;
        m_red   = 0;
        m_grn   = 0;
        m_blu   = 0;
    endtask

    task automatic model_edge();
        int old_st;
        bit fin;
        old_st  = m_st;
        m_red   = (old_st == 3) && (m_blink >= 8);
        m_grn   = (old_st == 2);
        m_blu   = (old_st == 1);
        m_blink = (m_blink + 1) % 16;
        if (old_st == 0) begin
            if (en) begin
                m_st  = 1;
                m_cyc = 0;
            end
        end else if (old_st == 1) begin
            fin = m_seen && !running;
            if (fin) begin
                m_st   = passed ? 2 : 3;
                m_snap = debug;
            end else if (m_cyc == 99) begin
                m_st   = 3;
                m_tmo  = 1;
                m_snap = debug;
            end
            m_cyc++;
            if (running) m_seen = 1;
        end
    endtask

    task automatic check_all();
        chk("state", 64'(st), 64'(m_st));
        chk("done", 64'(done), 64'(m_st >= 2));
        chk("timeout", 64'(tmo), 64'(m_tmo));
        chk("cycles", 64'(cycles), 64'(m_cyc));
        chk("snapshot", snap, m_snap);
        chk("red", 64'(red), 64'(m_red));
        chk("grn", 64'(grn), 64'(m_grn));
        chk("blu", 64'(blu), 64'(m_blu));
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_state"}, 64'(st), 64'd0);
        chk({pfx, "_done"}, 64'(done), 64'd0);
        chk({pfx, "_timeout"}, 64'(tmo), 64'd0);
        chk({pfx, "_cycles"}, 64'(cycles), 64'd0);
        chk({pfx, "_snapshot"}, snap, 64'd0);
        chk({pfx, "_leds"}, 64'({red, grn, blu}), 64'd0);
    endtask

    initial begin
        int mode;
        int rise;
        int fall;
        int idle;
        int extra;
        bit pass;
        bit do_rst;
        rst_n   = 1'b0;
        en      = 1'b0;
        running = 1'b0;
        passed  = 1'b0;
        debug   = '0;
        model_reset();
        #12;
        check_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 14; r++) begin
            mode = r % 5;
            rise = $urandom_range(1, 20);
            fall = rise + $urandom_range(1, 60);
            pass = 1'($urandom);
            if (mode == 0) pass = 1;
            if (mode == 1) pass = 0;
            if (mode == 2) rise = 1000;
            if (mode == 3) begin
                rise = 5;
                fall = 99;
                pass = 1;
            end
            if (mode == 4) begin
                rise = $urandom_range(0, 30);
                fall = rise + $urandom_range(1, 110);
            end
            do_rst = (r == 6);
            if (do_rst) begin
                rise = 5;
                fall = 1000;
            end
            idle  = $urandom_range(0, 4);
            extra = 0;

            for (int c = 0; c < 400 && extra < 15; c++) begin
                if (m_st == 0) begin
                    en      = (c >= idle);
                    running = 1'b0;
                    passed  = 1'($urandom);
                end else if (m_st == 1) begin
                    en      = 1'($urandom);
                    running = (m_cyc >= rise) && (m_cyc < fall);
                    passed  = pass;
                end else begin
                    en      = 1'($urandom);
                    running = 1'($urandom);
                    passed  = 1'($urandom);
                    extra++;
                end
                debug = {$urandom, $urandom};
                @(posedge clk);
                model_edge();
                #1;
                check_all();
                if (do_rst && m_st == 1 && m_cyc == 50) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check_zero("arst");
                    model_reset();
                    do_rst = 0;
                    @(negedge clk);
                    @(negedge clk);
                    rst_n = 1'b1;
                end
            end
            chk("run_end_done", 64'(done), 64'd1);

            @(negedge clk);
            rst_n = 1'b0;
            #1;
            model_reset();
            check_zero("rst");
            @(negedge clk);
            rst_n = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
